// File: rtl/ma_stage_pkg.sv
// Shared pipeline package: bus widths and field bit ranges for the EX->MA, MA->WB and MA forwarding buses.
// Producer and consumer stages slice buses with these constants so that both sides agree on the layout.
package ma_stage_pkg;

    localparam int EX_MA_BUS_W  = 71;
    localparam int MA_WB_BUS_W  = 70;
    localparam int MA_FWD_BUS_W = 38;

    // EX -> MA bus fields
    localparam int EM_RES_FROM_MEM = 70;
    localparam int EM_GR_WE        = 69;
    localparam int EM_DEST_HI      = 68;
    localparam int EM_DEST_LO      = 64;
    localparam int EM_ALU_HI       = 63;
    localparam int EM_ALU_LO       = 32;
    localparam int EM_PC_HI        = 31;
    localparam int EM_PC_LO        = 0;

    // MA -> WB bus fields
    localparam int MW_GR_WE        = 69;
    localparam int MW_DEST_HI      = 68;
    localparam int MW_DEST_LO      = 64;
    localparam int MW_RESULT_HI    = 63;
    localparam int MW_RESULT_LO    = 32;
    localparam int MW_PC_HI        = 31;
    localparam int MW_PC_LO        = 0;

    // MA forwarding bus fields
    localparam int FWD_WE          = 37;
    localparam int FWD_DEST_HI     = 36;
    localparam int FWD_DEST_LO     = 32;
    localparam int FWD_VALUE_HI    = 31;
    localparam int FWD_VALUE_LO    = 0;

endpackage

// File: rtl/ma_stage_load_hold.sv
// ma_load_hold: tracks the first MA cycle of an instruction and captures SRAM read data,
// so that load data stays stable however long write-back stalls.
module ma_load_hold
    import ma_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        accept,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] load_data
);

    logic        first;
    logic [31:0] rdata_hold;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first      <= 1'b0;
            // NOTE: this is a single register, not an array, so clearing it on reset costs nothing
            // and keeps the output bus at zero while reset is asserted.
            rdata_hold <= '0;
        end else begin
            first <= accept;
            if (valid && first) begin
                rdata_hold <= data_sram_rdata;
            end
        end
    end

    // SRAM data is only valid in the first MA cycle; afterwards the captured copy is used.
    assign load_data = first ? data_sram_rdata : rdata_hold;

endmodule

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage (EX -> MA -> WB) with valid/allowin handshake.
// Optional macro MA_FWD_EN adds ma_fwd_bus, a combinational bypass to the ID stage.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int IN_W  = EX_MA_BUS_W,
    parameter int OUT_W = MA_WB_BUS_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_validout,
    output logic                    ma_allowin,
    input  logic [IN_W-1:0]         ex_to_ma_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    wb_allowin,
    output logic                    ma_validout,
`ifdef MA_FWD_EN
    output logic [MA_FWD_BUS_W-1:0] ma_fwd_bus,
`endif
    output logic [OUT_W-1:0]        ma_to_wb_bus
);

    logic            valid;
    logic [IN_W-1:0] bus_r;
    logic            readygo;
    logic            accept;
    logic [31:0]     load_data;
    logic [31:0]     final_result;

    // Memory access completes in one cycle; the SRAM read was issued from execute.
    assign readygo     = 1'b1;
    assign ma_allowin  = ~valid | (readygo & wb_allowin);
    assign ma_validout = valid & readygo;
    assign accept      = ex_validout & ma_allowin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            bus_r <= '0;
        end else begin
            if (ma_allowin) begin
                valid <= ex_validout;
            end
            if (accept) begin
                bus_r <= ex_to_ma_bus;
            end
        end
    end

    ma_load_hold u_load_hold (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .accept         (accept),
        .data_sram_rdata(data_sram_rdata),
        .load_data      (load_data)
    );

    // Loads are word-only, so the SRAM word is the result as-is.
    assign final_result = bus_r[EM_RES_FROM_MEM] ? load_data : bus_r[EM_ALU_HI:EM_ALU_LO];

    // Driven from bus_r even when invalid; the consumer qualifies with ma_validout.
    assign ma_to_wb_bus = {bus_r[EM_GR_WE],
                           bus_r[EM_DEST_HI:EM_DEST_LO],
                           final_result,
                           bus_r[EM_PC_HI:EM_PC_LO]};

`ifdef MA_FWD_EN
    assign ma_fwd_bus = {valid & bus_r[EM_GR_WE],
                         bus_r[EM_DEST_HI:EM_DEST_LO],
                         final_result};
`endif

endmodule

// File: tb/tb_ma_stage.sv
// Directed self-checking bench for ma_stage; the forwarding checks are built when MA_FWD_EN is defined.
module tb_ma_stage;
    import ma_stage_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    ex_validout;
    logic                    ma_allowin;
    logic [70:0]             ex_to_ma_bus;
    logic [31:0]             data_sram_rdata;
    logic                    wb_allowin;
    logic                    ma_validout;
    logic [69:0]             ma_to_wb_bus;
`ifdef MA_FWD_EN
    logic [MA_FWD_BUS_W-1:0] ma_fwd_bus;
`endif

    int total = 0;
    int bad   = 0;

    ma_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_validout    (ex_validout),
        .ma_allowin     (ma_allowin),
        .ex_to_ma_bus   (ex_to_ma_bus),
        .data_sram_rdata(data_sram_rdata),
        .wb_allowin     (wb_allowin),
        .ma_validout    (ma_validout),
`ifdef MA_FWD_EN
        .ma_fwd_bus     (ma_fwd_bus),
`endif
        .ma_to_wb_bus   (ma_to_wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] mk_ex(input logic res, input logic we, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {res, we, dest, alu, pc};
    endfunction

    function automatic logic [69:0] mk_wb(input logic we, input logic [4:0] dest,
                                          input logic [31:0] result, input logic [31:0] pc);
        return {we, dest, result, pc};
    endfunction

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        ex_validout     = 1'b0;
        ex_to_ma_bus    = '0;
        data_sram_rdata = '0;
        wb_allowin      = 1'b1;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        check("rst_validout", 70'(ma_validout), 70'd0);
        check("rst_allowin",  70'(ma_allowin),  70'd1);
        check("rst_bus",      ma_to_wb_bus,     70'd0);
        step();
        rst = 1'b1;

        // Non-load pass-through
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk_ex(1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000);
        step();
        ex_to_ma_bus    = mk_ex(1'b1, 1'b1, 5'd3, 32'h0000_0099, 32'h1C00_0004);
        data_sram_rdata = 32'h0BAD_0BAD;
        #1;
        check("pass_validout", 70'(ma_validout), 70'd1);
        check("pass_bus", ma_to_wb_bus, mk_wb(1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000));

        // Load without stall: result is this cycle's SRAM data
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        ex_to_ma_bus    = mk_ex(1'b1, 1'b1, 5'd9, 32'h0000_0077, 32'h1C00_0008);
        #1;
        check("load_nostall", ma_to_wb_bus, mk_wb(1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1C00_0004));

        // Load with a 3-cycle stall; a new EX instruction waits
        step();
        wb_allowin      = 1'b0;
        ex_to_ma_bus    = mk_ex(1'b0, 1'b1, 5'd1, 32'hFFFF_FFFF, 32'h1C00_00F0);
        data_sram_rdata = 32'hCAFE_0001;
        #1;
        check("stall0_bus",     ma_to_wb_bus, mk_wb(1'b1, 5'd9, 32'hCAFE_0001, 32'h1C00_0008));
        check("stall0_allowin", 70'(ma_allowin), 70'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            data_sram_rdata = 32'h1111_1111;
            #1;
            check($sformatf("stall%0d_bus", i), ma_to_wb_bus,
                  mk_wb(1'b1, 5'd9, 32'hCAFE_0001, 32'h1C00_0008));
            check($sformatf("stall%0d_allowin", i), 70'(ma_allowin), 70'd0);
            check($sformatf("stall%0d_validout", i), 70'(ma_validout), 70'd1);
        end

        // Back-to-back loads: stalled load leaves as load A enters on the same edge
        wb_allowin   = 1'b1;
        ex_to_ma_bus = mk_ex(1'b1, 1'b1, 5'd10, 32'h0, 32'h1C00_0100);
        step();
        ex_to_ma_bus    = mk_ex(1'b1, 1'b0, 5'd11, 32'h0, 32'h1C00_0104);
        data_sram_rdata = 32'h0000_000A;
        #1;
        check("b2b_a", ma_to_wb_bus, mk_wb(1'b1, 5'd10, 32'h0000_000A, 32'h1C00_0100));
        step();
        ex_validout     = 1'b0;
        data_sram_rdata = 32'h0000_000B;
        #1;
        check("b2b_b", ma_to_wb_bus, mk_wb(1'b0, 5'd11, 32'h0000_000B, 32'h1C00_0104));
        check("b2b_b_validout", 70'(ma_validout), 70'd1);

        // Bubble: valid drops, bus and held load data keep their values
        step();
        data_sram_rdata = 32'h7777_7777;
        #1;
        check("bubble_validout", 70'(ma_validout), 70'd0);
        check("bubble_allowin",  70'(ma_allowin),  70'd1);
        check("bubble_bus", ma_to_wb_bus, mk_wb(1'b0, 5'd11, 32'h0000_000B, 32'h1C00_0104));

`ifdef MA_FWD_EN
        // Forwarding of a load in its first MA cycle, then a bubble
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk_ex(1'b1, 1'b1, 5'd7, 32'h0, 32'h1C00_0200);
        step();
        ex_validout     = 1'b0;
        data_sram_rdata = 32'h0000_0055;
        #1;
        check("fwd_load", 70'(ma_fwd_bus), 70'({1'b1, 5'd7, 32'h0000_0055}));
        step();
        #1;
        check("fwd_bubble_we", 70'(ma_fwd_bus[FWD_WE]), 70'd0);
`endif

        // Reset asserted mid-stall discards the held instruction
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk_ex(1'b1, 1'b1, 5'd12, 32'h0, 32'h1C00_0300);
        step();
        wb_allowin      = 1'b0;
        ex_validout     = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        step();
        #2 rst = 1'b0;
        #1;
        check("midrst_validout", 70'(ma_validout), 70'd0);
        check("midrst_allowin",  70'(ma_allowin),  70'd1);
        check("midrst_bus",      ma_to_wb_bus,     70'd0);
`ifdef MA_FWD_EN
        check("midrst_fwd", 70'(ma_fwd_bus), 70'd0);
`endif
        step();
        rst        = 1'b1;
        wb_allowin = 1'b1;
        step();
        check("post_rst_idle", 70'(ma_validout), 70'd0);

        // First instruction after release is accepted on the first edge with ex_validout=1
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk_ex(1'b0, 1'b1, 5'd2, 32'h0000_4321, 32'h1C00_0400);
        step();
        ex_validout = 1'b0;
        #1;
        check("post_rst_validout", 70'(ma_validout), 70'd1);
        check("post_rst_bus", ma_to_wb_bus, mk_wb(1'b1, 5'd2, 32'h0000_4321, 32'h1C00_0400));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
